// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction, ALU and writeback handshakes around alu_issue_ctrl.
// The controller uses the master side; the pipeline/ALU/consumer environment uses the slave side.
interface alu_issue_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 32,
  parameter int FUNC_WIDTH = 4
);
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [FUNC_WIDTH-1:0] alu_func;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  illegal;

  modport master (
    input  inst_valid, inst, rs1_data, rs2_data, alu_result, wb_ready,
    output inst_ready, alu_func, alu_op1, alu_op2, wb_valid, wb_rd, wb_data, illegal
  );

  modport slave (
    output inst_valid, inst, rs1_data, rs2_data, alu_result, wb_ready,
    input  inst_ready, alu_func, alu_op1, alu_op2, wb_valid, wb_rd, wb_data, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decodes one RV32 R/I-type ALU instruction, drives the registered ALU for a single
// issue cycle, captures its result and presents it on the writeback handshake.
//
// state   | meaning
// S_IDLE  | ready for an instruction; illegal ones pulse illegal and stay here
// S_ISSUE | latched func/operands driven to the ALU for one cycle
// S_CAPT  | ALU result (registered at end of ISSUE) captured into wb_data
// S_WB    | wb_valid high, wb_data/wb_rd held until wb_ready
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 32,
  parameter int FUNC_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_issue_ctrl_if.master  bus
);

  localparam logic [FUNC_WIDTH-1:0] F_ZERO = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_ADD  = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_SUB  = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_SLL  = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] F_SLT  = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] F_XOR  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] F_OR   = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] F_AND  = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] F_SRL  = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] F_SRA  = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] F_SLTU = FUNC_WIDTH'(10);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_A = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_WB} state_t;

  state_t                state_q, state_d;
  logic [FUNC_WIDTH-1:0] dec_func;
  logic [DATA_WIDTH-1:0] dec_op1, dec_op2;
  logic                  dec_ok;
  logic                  accept;
  logic [FUNC_WIDTH-1:0] lat_func;
  logic [DATA_WIDTH-1:0] lat_op1, lat_op2;
  logic [4:0]            lat_rd;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [4:0]            wb_rd_q;
  logic                  illegal_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = bus.inst[6:0];
  assign funct3 = bus.inst[14:12];
  assign funct7 = bus.inst[31:25];

  assign accept = bus.inst_valid && (state_q == S_IDLE);

  always_comb begin
    dec_func = F_ZERO;
    dec_ok   = 1'b0;
    dec_op1  = bus.rs1_data;
    dec_op2  = bus.rs2_data;
    if (opcode == OP_R) begin
      case (funct3)
        3'b000: begin
          if (funct7 == F7_0)      begin dec_func = F_ADD; dec_ok = 1'b1; end
          else if (funct7 == F7_A) begin dec_func = F_SUB; dec_ok = 1'b1; end
        end
        3'b101: begin
          if (funct7 == F7_0)      begin dec_func = F_SRL; dec_ok = 1'b1; end
          else if (funct7 == F7_A) begin dec_func = F_SRA; dec_ok = 1'b1; end
        end
        3'b001: if (funct7 == F7_0) begin dec_func = F_SLL;  dec_ok = 1'b1; end
        3'b010: if (funct7 == F7_0) begin dec_func = F_SLT;  dec_ok = 1'b1; end
        3'b011: if (funct7 == F7_0) begin dec_func = F_SLTU; dec_ok = 1'b1; end
        3'b100: if (funct7 == F7_0) begin dec_func = F_XOR;  dec_ok = 1'b1; end
        3'b110: if (funct7 == F7_0) begin dec_func = F_OR;   dec_ok = 1'b1; end
        default: if (funct7 == F7_0) begin dec_func = F_AND; dec_ok = 1'b1; end
      endcase
    end else if (opcode == OP_I) begin
      // immediate truncated to the datapath width; shift amounts are zero-extended
      dec_op2 = DATA_WIDTH'($signed(bus.inst[31:20]));
      case (funct3)
        3'b000: begin dec_func = F_ADD;  dec_ok = 1'b1; end
        3'b010: begin dec_func = F_SLT;  dec_ok = 1'b1; end
        3'b011: begin dec_func = F_SLTU; dec_ok = 1'b1; end
        3'b100: begin dec_func = F_XOR;  dec_ok = 1'b1; end
        3'b110: begin dec_func = F_OR;   dec_ok = 1'b1; end
        3'b111: begin dec_func = F_AND;  dec_ok = 1'b1; end
        3'b001: begin
          dec_op2 = DATA_WIDTH'(bus.inst[24:20]);
          if (funct7 == F7_0) begin dec_func = F_SLL; dec_ok = 1'b1; end
        end
        default: begin
          dec_op2 = DATA_WIDTH'(bus.inst[24:20]);
          if (funct7 == F7_0)      begin dec_func = F_SRL; dec_ok = 1'b1; end
          else if (funct7 == F7_A) begin dec_func = F_SRA; dec_ok = 1'b1; end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && dec_ok) state_d = S_ISSUE;
      S_ISSUE: state_d = S_CAPT;
      S_CAPT:  state_d = S_WB;
      default: if (bus.wb_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_func  <= F_ZERO;
      lat_op1   <= '0;
      lat_op2   <= '0;
      lat_rd    <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !dec_ok;
      if (accept && dec_ok) begin
        lat_func <= dec_func;
        lat_op1  <= dec_op1;
        lat_op2  <= dec_op2;
        lat_rd   <= bus.inst[11:7];
      end
      if (state_q == S_CAPT) begin
        wb_data_q <= bus.alu_result;
        wb_rd_q   <= lat_rd;
      end
    end
  end

  // outside ISSUE the ALU sees ZERO so it holds its last result
  always_comb begin
    bus.inst_ready = (state_q == S_IDLE);
    bus.wb_valid   = (state_q == S_WB);
    bus.alu_func   = F_ZERO;
    bus.alu_op1    = '0;
    bus.alu_op2    = '0;
    if (state_q == S_ISSUE) begin
      bus.alu_func = lat_func;
      bus.alu_op1  = lat_op1;
      bus.alu_op2  = lat_op2;
    end
    bus.wb_data = wb_data_q;
    bus.wb_rd   = wb_rd_q;
    bus.illegal = illegal_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered 8-bit ALU.
module tb_alu_issue_ctrl;
  localparam int DW = 8;
  localparam int IW = 32;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [DW-1:0] alu_q = '0;

  alu_issue_ctrl_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .FUNC_WIDTH(FW)) bus ();

  alu_issue_ctrl #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .FUNC_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_model(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (f)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a << b;
      4'd4:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      4'd5:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return a >> b;
      4'd9:    return DW'($signed(a) >>> b);
      4'd10:   return (a < b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // registered ALU: ZERO holds the previous result
  always @(posedge clk) begin
    if (bus.alu_func != 4'd0) alu_q <= alu_model(bus.alu_func, bus.alu_op1, bus.alu_op2);
  end
  assign bus.alu_result = alu_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_inst(input string tag, input logic [31:0] i, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] f, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [4:0] rd, input logic [7:0] res);
    bus.inst = i; bus.rs1_data = a; bus.rs2_data = b;
    bus.inst_valid = 1'b1; bus.wb_ready = 1'b1;
    check({tag, ".ready"}, 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0; bus.rs1_data = 8'hEE; bus.rs2_data = 8'hEE;
    #1;
    check({tag, ".func"}, 32'(bus.alu_func), 32'(f));
    check({tag, ".op1"}, 32'(bus.alu_op1), 32'(e1));
    check({tag, ".op2"}, 32'(bus.alu_op2), 32'(e2));
    check({tag, ".busy"}, 32'(bus.inst_ready), 32'd0);
    tick();
    check({tag, ".capt_valid"}, 32'(bus.wb_valid), 32'd0);
    check({tag, ".capt_func"}, 32'(bus.alu_func), 32'd0);
    tick();
    check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
    check({tag, ".wb_rd"}, 32'(bus.wb_rd), 32'(rd));
    check({tag, ".wb_data"}, 32'(bus.wb_data), 32'(res));
    tick();
    check({tag, ".idle_ready"}, 32'(bus.inst_ready), 32'd1);
    check({tag, ".idle_valid"}, 32'(bus.wb_valid), 32'd0);
  endtask

  logic [31:0] ill_insts [3] = '{32'h40109093, 32'h00008083, 32'h022081B3};

  initial begin
    bus.inst_valid = 1'b0; bus.inst = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.wb_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("rst.ready", 32'(bus.inst_ready), 32'd1);
    check("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst.func", 32'(bus.alu_func), 32'd0);
    check("rst.op1", 32'(bus.alu_op1), 32'd0);
    check("rst.op2", 32'(bus.alu_op2), 32'd0);
    check("rst.wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst.wb_data", 32'(bus.wb_data), 32'd0);
    check("rst.illegal", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    tick();

    run_inst("add",  32'h002081B3, 8'h05, 8'h03, 4'd1,  8'h05, 8'h03, 5'd3,  8'h08);
    run_inst("sub",  32'h402082B3, 8'h03, 8'h05, 4'd2,  8'h03, 8'h05, 5'd5,  8'hFE);
    run_inst("addi", 32'hFFF08313, 8'h10, 8'h55, 4'd1,  8'h10, 8'hFF, 5'd6,  8'h0F);
    run_inst("srai", 32'h4020D213, 8'h80, 8'h77, 4'd9,  8'h80, 8'h02, 5'd4,  8'hE0);
    run_inst("and",  32'h0020F3B3, 8'hC3, 8'h5A, 4'd7,  8'hC3, 8'h5A, 5'd7,  8'h42);
    run_inst("sltu", 32'h0020B433, 8'h05, 8'hF0, 4'd10, 8'h05, 8'hF0, 5'd8,  8'h01);
    run_inst("slt",  32'h0020A4B3, 8'h05, 8'hF0, 4'd4,  8'h05, 8'hF0, 5'd9,  8'h00);
    run_inst("srl",  32'h0020D533, 8'h80, 8'h03, 4'd8,  8'h80, 8'h03, 5'd10, 8'h10);
    run_inst("xori", 32'h00F0C593, 8'hAA, 8'h33, 4'd5,  8'hAA, 8'h0F, 5'd11, 8'hA5);
    run_inst("add0", 32'h00208033, 8'h01, 8'h01, 4'd1,  8'h01, 8'h01, 5'd0,  8'h02);

    // backpressure: or x12 stalls in WB while a new add waits at the input
    bus.wb_ready = 1'b0;
    bus.inst = 32'h0020E633; bus.rs1_data = 8'h0F; bus.rs2_data = 8'hF0; bus.inst_valid = 1'b1;
    tick();
    check("bp.func", 32'(bus.alu_func), 32'd6);
    bus.inst = 32'h002081B3; bus.rs1_data = 8'h20; bus.rs2_data = 8'h01;
    tick(); tick();
    check("bp.wb_valid", 32'(bus.wb_valid), 32'd1);
    check("bp.wb_data", 32'(bus.wb_data), 32'hFF);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp.hold_valid", 32'(bus.wb_valid), 32'd1);
      check("bp.hold_data", 32'(bus.wb_data), 32'hFF);
      check("bp.hold_rd", 32'(bus.wb_rd), 32'd12);
      check("bp.hold_ready", 32'(bus.inst_ready), 32'd0);
      check("bp.hold_func", 32'(bus.alu_func), 32'd0);
    end
    bus.wb_ready = 1'b1;
    tick();
    check("bp.release_valid", 32'(bus.wb_valid), 32'd0);
    check("bp.release_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    check("bp.next_func", 32'(bus.alu_func), 32'd1);
    check("bp.next_op1", 32'(bus.alu_op1), 32'h20);
    check("bp.next_op2", 32'(bus.alu_op2), 32'h01);
    tick(); tick();
    check("bp.next_valid", 32'(bus.wb_valid), 32'd1);
    check("bp.next_data", 32'(bus.wb_data), 32'h21);
    check("bp.next_rd", 32'(bus.wb_rd), 32'd3);
    tick();

    // illegal encodings: one-cycle pulse, no issue, no writeback
    for (int k = 0; k < 3; k++) begin
      bus.inst = ill_insts[k]; bus.rs1_data = 8'h11; bus.rs2_data = 8'h22; bus.inst_valid = 1'b1;
      tick();
      bus.inst_valid = 1'b0;
      check("ill.pulse", 32'(bus.illegal), 32'd1);
      check("ill.ready", 32'(bus.inst_ready), 32'd1);
      check("ill.func", 32'(bus.alu_func), 32'd0);
      tick();
      check("ill.pulse_end", 32'(bus.illegal), 32'd0);
      check("ill.func2", 32'(bus.alu_func), 32'd0);
      tick(); tick();
      check("ill.no_wb", 32'(bus.wb_valid), 32'd0);
    end

    // reset while in CAPT drops the instruction
    bus.inst = 32'h002081B3; bus.rs1_data = 8'h05; bus.rs2_data = 8'h03; bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstc.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rstc.wb_data", 32'(bus.wb_data), 32'd0);
    check("rstc.func", 32'(bus.alu_func), 32'd0);
    check("rstc.ready", 32'(bus.inst_ready), 32'd1);
    tick(); tick(); tick();
    check("rstc.no_wb", 32'(bus.wb_valid), 32'd0);
    run_inst("post_rst", 32'h002081B3, 8'h07, 8'h09, 4'd1, 8'h07, 8'h09, 5'd3, 8'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. It accepts one RISC-V R-type or I-type ALU instruction over a valid/ready handshake and decodes it into the ALU func code and operands. It drives the registered 1-cycle ALU for exactly one issue cycle, captures the ALU result, and presents it on a valid/ready writeback port. It sits between the instruction/register-read stage and the ALU, and owns all func encoding.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU datapath width
INST_WIDTH, 32, instruction width; fixed RV32 encoding
FUNC_WIDTH, 4, ALU func code width (codes 0..10)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
inst_valid  input  1  instruction and operands valid
inst_ready  output  1  controller can accept (IDLE only)
inst  input  INST_WIDTH  instruction word
rs1_data  input  DATA_WIDTH  rs1 register value
rs2_data  input  DATA_WIDTH  rs2 register value
alu_func  output  FUNC_WIDTH  func code to ALU
alu_op1  output  DATA_WIDTH  ALU operand 1
alu_op2  output  DATA_WIDTH  ALU operand 2
alu_result  input  DATA_WIDTH  registered ALU result
wb_valid  output  1  writeback data valid
wb_ready  input  1  writeback consumer ready
wb_rd  output  5  destination register, inst[11:7]
wb_data  output  DATA_WIDTH  captured ALU result
illegal  output  1  one-cycle pulse: accepted instruction not decodable

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; alu_func=0 (ZERO), alu_op1=alu_op2=0, wb_valid=0, wb_rd=0, wb_data=0, illegal=0. inst_ready=1 from the first cycle after rst deasserts.
- Func codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.
- Decode for opcode 0110011 (R-type), keyed on funct3/funct7:
  - funct3 000: funct7 0000000 -> ADD; funct7 0100000 -> SUB.
  - 001 -> SLL, 010 -> SLT, 011 -> SLTU, 100 -> XOR, 110 -> OR, 111 -> AND (these require funct7=0000000).
  - 101: funct7 0000000 -> SRL; 0100000 -> SRA.
  - op1=rs1_data, op2=rs2_data.
- Decode for opcode 0010011 (I-type): same funct3 map, no SUB. op1=rs1_data.
  - Non-shift: op2 = low DATA_WIDTH bits of sign-extended inst[31:20].
  - Shifts: op2 = zero-extended inst[24:20].
  - funct3 001 requires inst[31:25]=0000000.
  - funct3 101: inst[31:25] 0000000 -> SRL, 0100000 -> SRA.
- Any other opcode/funct combination is illegal.
- FSM: IDLE -> ISSUE -> CAPT -> WB -> IDLE.
  - IDLE: inst_ready=1. On inst_valid&&inst_ready, latch decoded func, operands and rd.
    - If illegal: pulse illegal=1 the next cycle, remain IDLE, no ALU activity, no writeback.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): alu_func/alu_op1/alu_op2 = latched values. In every other state, alu_func=ZERO and ops=0, so the ALU holds its result.
  - CAPT (1 cycle): wb_data <= alu_result (the ALU registered the result at the end of ISSUE); wb_rd <= latched rd.
  - WB: wb_valid=1. wb_data and wb_rd are held stable until wb_valid&&wb_ready; on that edge go to IDLE.
- Latency: acceptance edge E, then ISSUE in cycle E+1, CAPT in E+2, wb_valid first high in E+3. Minimum 4 cycles per instruction.
- inst_ready=0 in ISSUE, CAPT and WB; inst_valid is ignored there, and rs1/rs2 changes have no effect after acceptance.
- rd=0 is still written back with wb_rd=0; discarding it is the consumer's job.
- rst asserted in any state: next cycle IDLE with all reset values. The in-flight instruction is dropped and wb_valid never asserts for it.

Test Plan:
1. rst, then inst=0x002081B3 (add x3,x1,x2), rs1=0x05, rs2=0x03, wb_ready=1 -> ISSUE cycle shows func=1, op1=0x05, op2=0x03; wb_valid at E+3 with wb_rd=3, wb_data=0x08; inst_ready=1 the next cycle.
2. inst=0x402082B3 (sub x5), rs1=0x03, rs2=0x05 -> func=2; wb_rd=5, wb_data=0xFE.
3. inst=0xFFF08313 (addi x6,x1,-1), rs1=0x10 -> func=1, op2=0xFF, wb_data=0x0F. Then inst=0x4020D213 (srai x4,x1,2) -> func=9, op2=0x02, wb_rd=4.
4. Backpressure: wb_ready=0 for 5 cycles in WB, with inst_valid=1 and a new inst -> wb_valid/wb_data/wb_rd stable, inst_ready=0, no new issue; raise wb_ready -> IDLE next cycle, then the new inst is accepted.
5. Illegal: inst=0x40109093 (slli with funct7=0100000), then opcode 0000011 -> each gives illegal high exactly 1 cycle, alu_func stays 0, wb_valid never asserts, inst_ready=1 the following cycle.
6. Assert rst for 1 cycle while in CAPT -> next cycle IDLE, wb_valid=0, wb_data=0, alu_func=0. A following add executes normally.
